// File: rtl/sys_bus_pkg.sv
// Shared types and default address map for the system bus controller.
package sys_bus_pkg;

    localparam int unsigned BUS_ADDR_W = 32;
    localparam int unsigned BUS_DATA_W = 32;
    localparam int unsigned DEF_N_SLV  = 2;

    // Default windows: memory at 0x000-0x3FF, I/O at 0x400-0x7FF.
    localparam logic [31:0] MEM_BASE = 32'h0000_0000;
    localparam logic [31:0] IO_BASE  = 32'h0000_0400;
    localparam logic [31:0] WIN_MASK = 32'hFFFF_FC00;

    localparam logic [63:0] DEF_SLV_BASE = {IO_BASE, MEM_BASE};
    localparam logic [63:0] DEF_SLV_MASK = {WIN_MASK, WIN_MASK};

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } bus_state_e;

endpackage

// File: rtl/sys_bus_ctrl_if.sv
// Bus bundle between the CPU, the controller and the slaves.
interface sys_bus_ctrl_if #(
    parameter int unsigned ADDR_W = sys_bus_pkg::BUS_ADDR_W,
    parameter int unsigned DATA_W = sys_bus_pkg::BUS_DATA_W,
    parameter int unsigned N_SLV  = sys_bus_pkg::DEF_N_SLV
);
    // CPU side
    logic                    m_req;
    logic                    m_we;
    logic [ADDR_W-1:0]       m_addr;
    logic [DATA_W-1:0]       m_wdata;
    logic [DATA_W-1:0]       m_rdata;
    logic                    m_ack;
    logic                    m_err;
    logic                    busy;
    // Slave side
    logic [N_SLV-1:0]        s_sel;
    logic                    s_we;
    logic [ADDR_W-1:0]       s_addr;
    logic [DATA_W-1:0]       s_wdata;
    logic [N_SLV*DATA_W-1:0] s_rdata;
    logic [N_SLV-1:0]        s_ready;

    // The controller masters the system bus: it answers the CPU and drives the slaves.
    modport master (
        input  m_req, m_we, m_addr, m_wdata, s_rdata, s_ready,
        output m_rdata, m_ack, m_err, busy, s_sel, s_we, s_addr, s_wdata
    );

    // Environment view: CPU requests plus slave responses.
    modport slave (
        output m_req, m_we, m_addr, m_wdata, s_rdata, s_ready,
        input  m_rdata, m_ack, m_err, busy, s_sel, s_we, s_addr, s_wdata
    );

endinterface

// File: rtl/sys_bus_decoder.sv
// Address-window decoder: one-hot select, lowest matching window wins.
module sys_bus_decoder
    import sys_bus_pkg::*;
#(
    parameter int unsigned             ADDR_W   = BUS_ADDR_W,
    parameter int unsigned             N_SLV    = DEF_N_SLV,
    parameter logic [N_SLV*ADDR_W-1:0] SLV_BASE = DEF_SLV_BASE,
    parameter logic [N_SLV*ADDR_W-1:0] SLV_MASK = DEF_SLV_MASK
) (
    input  logic [ADDR_W-1:0] addr_i,
    output logic [N_SLV-1:0]  sel_o,
    output logic              hit_o
);

    logic found;

    // Priority scan from window 0 upward; first match claims the access.
    always_comb begin
        sel_o = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < N_SLV; i++) begin
            if (!found &&
                ((addr_i & SLV_MASK[i*ADDR_W +: ADDR_W]) == SLV_BASE[i*ADDR_W +: ADDR_W])) begin
                sel_o[i] = 1'b1;
                found    = 1'b1;
            end
        end
        hit_o = found;
    end

endmodule

// File: rtl/sys_bus_ctrl.sv
// Single-master bus controller: window decode, wait-state handshake, timeout, error response.
module sys_bus_ctrl
    import sys_bus_pkg::*;
#(
    parameter int unsigned             ADDR_W   = BUS_ADDR_W,
    parameter int unsigned             DATA_W   = BUS_DATA_W,
    parameter int unsigned             N_SLV    = DEF_N_SLV,
    parameter logic [N_SLV*ADDR_W-1:0] SLV_BASE = DEF_SLV_BASE,
    parameter logic [N_SLV*ADDR_W-1:0] SLV_MASK = DEF_SLV_MASK,
    parameter int unsigned             TIMEOUT  = 16
) (
    input  logic          clk,
    input  logic          rst,
    sys_bus_ctrl_if.master bus
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    bus_state_e        state_q, state_d;
    logic [N_SLV-1:0]  sel_q, sel_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              ack_q, ack_d;
    logic              err_q, err_d;
    logic              busy_q, busy_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic [N_SLV-1:0]  dec_sel;
    logic              dec_hit;
    logic              sel_ready;
    logic [DATA_W-1:0] sel_rdata;

    sys_bus_decoder #(
        .ADDR_W   (ADDR_W),
        .N_SLV    (N_SLV),
        .SLV_BASE (SLV_BASE),
        .SLV_MASK (SLV_MASK)
    ) u_dec (
        .addr_i (bus.m_addr),
        .sel_o  (dec_sel),
        .hit_o  (dec_hit)
    );

    // Ready and read data of the currently selected slave only; sel_q is zero outside ACCESS.
    always_comb begin
        sel_ready = |(bus.s_ready & sel_q);
        sel_rdata = '0;
        for (int unsigned i = 0; i < N_SLV; i++) begin
            if (sel_q[i]) begin
                sel_rdata = sel_rdata | bus.s_rdata[i*DATA_W +: DATA_W];
            end
        end
    end

    // Next-state and next-register logic.
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        ack_d   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.m_req) begin
                    if (dec_hit) begin
                        state_d = ST_ACCESS;
                        sel_d   = dec_sel;
                        we_d    = bus.m_we;
                        addr_d  = bus.m_addr;
                        wdata_d = bus.m_wdata;
                        cnt_d   = '0;
                    end else begin
                        state_d = ST_RESP;
                        err_d   = 1'b1;
                        rdata_d = '0;
                        ack_d   = 1'b1;
                    end
                end
            end
            ST_ACCESS: begin
                // Ready is checked before the timeout so it wins on the last permitted cycle.
                if (sel_ready) begin
                    state_d = ST_RESP;
                    rdata_d = we_q ? '0 : sel_rdata;
                    err_d   = 1'b0;
                    ack_d   = 1'b1;
                    sel_d   = '0;
                    we_d    = 1'b0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_RESP;
                    rdata_d = '0;
                    err_d   = 1'b1;
                    ack_d   = 1'b1;
                    sel_d   = '0;
                    we_d    = 1'b0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
                err_d   = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
                sel_d   = '0;
                we_d    = 1'b0;
                err_d   = 1'b0;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers; reset aborts any access in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            sel_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.m_rdata = rdata_q;
    assign bus.m_ack   = ack_q;
    assign bus.m_err   = err_q;
    assign bus.busy    = busy_q;
    assign bus.s_sel   = sel_q;
    assign bus.s_we    = we_q;
    assign bus.s_addr  = addr_q;
    assign bus.s_wdata = wdata_q;

endmodule

// File: tb/tb_sys_bus_ctrl.sv
// Directed plus randomized bench for sys_bus_ctrl against a transaction-level model.
module tb_sys_bus_ctrl;

    localparam int unsigned ADDR_W  = 32;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned N_SLV   = 2;
    localparam int          TIMEOUT = 16;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_fail;

    // Address map as seen by the model: window i covers addresses whose masked value equals base.
    logic [31:0] map_base [N_SLV];
    logic [31:0] map_mask [N_SLV];

    sys_bus_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .N_SLV(N_SLV)) bus ();

    sys_bus_ctrl #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .N_SLV    (N_SLV),
        .SLV_BASE ({32'h0000_0400, 32'h0000_0000}),
        .SLV_MASK ({32'hFFFF_FC00, 32'hFFFF_FC00}),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Lowest matching window index, or -1 when the address is unmapped.
    function automatic int model_decode(input logic [31:0] addr);
        for (int i = 0; i < N_SLV; i++) begin
            if ((addr & map_mask[i]) == map_base[i]) return i;
        end
        return -1;
    endfunction

    // wait_n: ACCESS cycles before the slave raises ready (0 = zero-wait), negative = never.
    task automatic run_txn(input logic [31:0] addr, input logic we, input logic [31:0] wdata,
                           input int wait_n, input logic [31:0] rd_val, input bit hold,
                           input string tag);
        int         idx;
        int         lat;
        logic       exp_err;
        logic [31:0] exp_rd;
        logic [1:0] exp_sel;
        logic [1:0] noise;
        logic [63:0] rd_bus;

        idx = model_decode(addr);
        if (idx < 0) begin
            lat = 1; exp_err = 1'b1; exp_rd = '0; exp_sel = 2'b00;
        end else begin
            exp_sel = 2'b00;
            exp_sel[idx] = 1'b1;
            if (wait_n >= 0 && wait_n < TIMEOUT) begin
                lat = wait_n + 2; exp_err = 1'b0; exp_rd = we ? 32'h0 : rd_val;
            end else begin
                lat = TIMEOUT + 1; exp_err = 1'b1; exp_rd = '0;
            end
        end

        // Request sample cycle; slave ready noise must be ignored in IDLE.
        bus.m_req   = 1'b1;
        bus.m_addr  = addr;
        bus.m_we    = we;
        bus.m_wdata = wdata;
        bus.s_ready = 2'($urandom);
        bus.s_rdata = {$urandom, $urandom};

        for (int c = 1; c <= lat; c++) begin
            tick();
            if (!hold) bus.m_req = 1'b0;
            bus.m_addr  = $urandom;
            bus.m_we    = 1'($urandom);
            bus.m_wdata = $urandom;
            if (c < lat) begin
                check({tag, ".ack_low"}, 64'(bus.m_ack), 64'(1'b0));
                check({tag, ".busy"},    64'(bus.busy),  64'(1'b1));
                check({tag, ".s_sel"},   64'(bus.s_sel), 64'(exp_sel));
                check({tag, ".s_we"},    64'(bus.s_we),  64'(we));
                check({tag, ".s_addr"},  64'(bus.s_addr), 64'(addr));
                check({tag, ".s_wdata"}, 64'(bus.s_wdata), 64'(wdata));
                noise  = 2'($urandom);
                rd_bus = {$urandom, $urandom};
                rd_bus[idx*32 +: 32] = rd_val;
                bus.s_rdata = rd_bus;
                bus.s_ready = (noise & ~exp_sel) | ((c - 1 == wait_n) ? exp_sel : 2'b00);
            end else begin
                check({tag, ".ack"},     64'(bus.m_ack),   64'(1'b1));
                check({tag, ".err"},     64'(bus.m_err),   64'(exp_err));
                check({tag, ".rdata"},   64'(bus.m_rdata), 64'(exp_rd));
                check({tag, ".sel_off"}, 64'(bus.s_sel),   64'(2'b00));
                check({tag, ".busy_r"},  64'(bus.busy),    64'(1'b1));
                bus.s_ready = 2'($urandom);
            end
        end

        tick();
        check({tag, ".idle_busy"}, 64'(bus.busy),  64'(1'b0));
        check({tag, ".idle_ack"},  64'(bus.m_ack), 64'(1'b0));
        check({tag, ".idle_sel"},  64'(bus.s_sel), 64'(2'b00));
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        map_base[0] = 32'h0000_0000; map_mask[0] = 32'hFFFF_FC00;
        map_base[1] = 32'h0000_0400; map_mask[1] = 32'hFFFF_FC00;

        rst         = 1'b1;
        bus.m_req   = 1'b0;
        bus.m_we    = 1'b0;
        bus.m_addr  = '0;
        bus.m_wdata = '0;
        bus.s_rdata = '0;
        bus.s_ready = '0;
        repeat (3) tick();

        check("rst.s_sel",   64'(bus.s_sel),   64'(2'b00));
        check("rst.s_we",    64'(bus.s_we),    64'(1'b0));
        check("rst.s_addr",  64'(bus.s_addr),  64'(32'h0));
        check("rst.s_wdata", 64'(bus.s_wdata), 64'(32'h0));
        check("rst.m_rdata", 64'(bus.m_rdata), 64'(32'h0));
        check("rst.m_ack",   64'(bus.m_ack),   64'(1'b0));
        check("rst.m_err",   64'(bus.m_err),   64'(1'b0));
        check("rst.busy",    64'(bus.busy),    64'(1'b0));
        rst = 1'b0;
        tick();

        // Zero-wait read of memory.
        run_txn(32'h0000_0010, 1'b0, 32'h1234_5678, 0, 32'hDEAD_BEEF, 1'b0, "rd0");
        // Write to I/O with three wait states.
        run_txn(32'h0000_0404, 1'b1, 32'h0000_00A5, 3, 32'hCAFE_F00D, 1'b0, "wr1");
        // Unmapped access.
        run_txn(32'h0000_0800, 1'b0, 32'h0, 0, 32'h1111_2222, 1'b0, "unmap");
        // Slave never ready: timeout error.
        run_txn(32'h0000_0400, 1'b0, 32'h0, -1, 32'h3333_4444, 1'b0, "tmo");
        // Ready in the last permitted ACCESS cycle beats the timeout.
        run_txn(32'h0000_0400, 1'b0, 32'h0, TIMEOUT - 1, 32'h5555_6666, 1'b0, "tmo_edge");
        // Back-to-back reads with m_req held high.
        run_txn(32'h0000_0000, 1'b0, 32'h0, 0, 32'hA0A0_0001, 1'b1, "b2b0");
        run_txn(32'h0000_0400, 1'b0, 32'h0, 0, 32'hA0A0_0002, 1'b1, "b2b1");
        run_txn(32'h0000_0000, 1'b0, 32'h0, 0, 32'hA0A0_0003, 1'b0, "b2b2");

        // Reset asserted in the second ACCESS cycle aborts without an ack.
        bus.m_req   = 1'b1;
        bus.m_we    = 1'b0;
        bus.m_addr  = 32'h0000_0010;
        bus.s_ready = 2'b00;
        tick();
        bus.m_req = 1'b0;
        check("abort.sel1", 64'(bus.s_sel), 64'(2'b01));
        tick();
        check("abort.sel2", 64'(bus.s_sel), 64'(2'b01));
        rst = 1'b1;
        #1;
        check("abort.s_sel",  64'(bus.s_sel),  64'(2'b00));
        check("abort.busy",   64'(bus.busy),   64'(1'b0));
        check("abort.ack",    64'(bus.m_ack),  64'(1'b0));
        check("abort.s_addr", 64'(bus.s_addr), 64'(32'h0));
        for (int k = 0; k < 2; k++) begin
            bus.s_ready = 2'b11;
            tick();
            check("abort.no_ack", 64'(bus.m_ack), 64'(1'b0));
        end
        rst = 1'b0;
        bus.s_ready = 2'b00;
        tick();
        check("abort.idle", 64'(bus.busy), 64'(1'b0));
        run_txn(32'h0000_0020, 1'b0, 32'h0, 1, 32'h0BAD_F00D, 1'b0, "post_rst");

        // Randomized transactions.
        for (int t = 0; t < 40; t++) begin
            logic [31:0] a;
            int          w;
            int          kind;
            kind = int'($urandom_range(0, 2));
            if (kind == 0)      a = {22'h0, 10'($urandom)};
            else if (kind == 1) a = 32'h0000_0400 | {22'h0, 10'($urandom)};
            else                a = $urandom | 32'h0000_0800;
            w = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, 5));
            run_txn(a, 1'($urandom), $urandom, w, $urandom,
                    (t != 39) && ($urandom_range(0, 1) == 1), "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
